// File: rtl/lsu_pkg.sv
// Shared LSU definitions: access-size encodings, responder states and the data-memory window.
package lsu_pkg;

   localparam logic [1:0] LSU_BYTE = 2'b00;
   localparam logic [1:0] LSU_HALF = 2'b01;
   localparam logic [1:0] LSU_WORD = 2'b10;

   localparam int unsigned DMEM_DEPTH_WORDS = 512;
   localparam logic [31:0] DMEM_BASE        = 32'h0000_0000;
   localparam logic [31:0] DMEM_LIMIT       = DMEM_BASE + 32'(4 * DMEM_DEPTH_WORDS) - 32'd1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      RESP  = 2'd3
   } lsu_rsp_state_e;

   // Byte lanes touched by an access starting at lane 0; size 11 behaves as a word.
   function automatic logic [3:0] lsu_lane_mask(input logic [1:0] size);
      case (size)
         LSU_BYTE: lsu_lane_mask = 4'b0001;
         LSU_HALF: lsu_lane_mask = 4'b0011;
         default:  lsu_lane_mask = 4'b1111;
      endcase
   endfunction

   function automatic logic [1:0] lsu_span_m1(input logic [1:0] size);
      case (size)
         LSU_BYTE: lsu_span_m1 = 2'd0;
         LSU_HALF: lsu_span_m1 = 2'd1;
         default:  lsu_span_m1 = 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/sp_bram.sv
// Single-port data RAM, 32-bit words with per-byte write enables and a registered read port.
module sp_bram #(
   parameter int unsigned DEPTH_WORDS = 512,
   parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          i_clk,
   input  logic          i_en,
   input  logic [3:0]    i_be,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Read returns the pre-write contents; o_rdata holds whenever i_en is low.
   always_ff @(posedge i_clk) begin
      if (i_en) begin
         for (int b = 0; b < 4; b++) begin
            if (i_be[b]) begin
               mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
         o_rdata <= mem[i_addr];
      end
   end

endmodule

// File: rtl/lsu_mem_responder.sv
// LSU memory responder: one request at a time, misaligned accesses split into two RAM beats,
// loads merged and extended before being returned on a valid/ready response channel.
module lsu_mem_responder
   import lsu_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
   parameter logic [31:0] BASE_ADDR   = DMEM_BASE
) (
   input  logic           i_clk,
   input  logic           i_reset,
   input  logic           i_req_valid,
   output logic           o_req_ready,
   input  logic [31:0]    i_req_addr,
   input  logic           i_req_wren,
   input  logic [1:0]     i_req_size,
   input  logic           i_req_signed,
   input  logic [31:0]    i_req_wdata,
   output logic           o_rsp_valid,
   input  logic           i_rsp_ready,
   output logic [31:0]    o_rsp_rdata,
   output logic           o_rsp_err,
   output lsu_rsp_state_e o_dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid && ready are both high;
   // req_ready only in IDLE and rsp_valid only in RESP, so the two channels never fire together.

   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [33:0] LIMIT_REL = 34'(4 * DEPTH_WORDS) - 34'd1;

   lsu_rsp_state_e state_q, state_d;
   logic [AW-1:0]  word_q, word_d;
   logic [1:0]     off_q, size_q, size_d;
   logic           wren_q, signed_q, split_q, err_q;
   logic [3:0]     mask0_q, mask1_q;
   logic [31:0]    wdata_q, wdata_d;
   logic [23:0]    hold_q;

   logic [33:0]    rel_addr, last_rel;
   logic           req_err, accept;
   logic [7:0]     lanes;

   logic           ram_en;
   logic [3:0]     ram_be;
   logic [AW-1:0]  ram_addr;
   logic [31:0]    ram_rdata;
   logic [31:0]    aligned, load_val;

   assign accept = i_req_valid && (state_q == IDLE);

   // 34-bit offset math: bit 33 flags an address below the window, and the last byte
   // of an access can never carry into it, so a wrap past the top shows up as > LIMIT_REL.
   always_comb begin
      rel_addr = {2'b00, i_req_addr} - {2'b00, BASE_ADDR};
      last_rel = rel_addr + {32'd0, lsu_span_m1(i_req_size)};
      req_err  = rel_addr[33] || (last_rel > LIMIT_REL);
      word_d   = rel_addr[AW+1:2];
      lanes    = {4'b0000, lsu_lane_mask(i_req_size)} << i_req_addr[1:0];
      size_d   = (i_req_size == 2'b11) ? LSU_WORD : i_req_size;
      case (i_req_addr[1:0])
         2'd1:    wdata_d = {i_req_wdata[23:0], i_req_wdata[31:24]};
         2'd2:    wdata_d = {i_req_wdata[15:0], i_req_wdata[31:16]};
         2'd3:    wdata_d = {i_req_wdata[7:0],  i_req_wdata[31:8]};
         default: wdata_d = i_req_wdata;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= IDLE;
         word_q   <= '0;
         off_q    <= '0;
         size_q   <= '0;
         wren_q   <= 1'b0;
         signed_q <= 1'b0;
         split_q  <= 1'b0;
         err_q    <= 1'b0;
         mask0_q  <= '0;
         mask1_q  <= '0;
         wdata_q  <= '0;
         hold_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            word_q   <= word_d;
            off_q    <= i_req_addr[1:0];
            size_q   <= size_d;
            wren_q   <= i_req_wren;
            signed_q <= i_req_signed;
            split_q  <= |lanes[7:4];
            err_q    <= req_err;
            mask0_q  <= lanes[3:0];
            mask1_q  <= lanes[7:4];
            wdata_q  <= wdata_d;
         end
         // Lane 0 of the first word is never part of a split access.
         if (state_q == BEAT1) begin
            hold_q <= ram_rdata[31:8];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ram_en   = 1'b0;
      ram_addr = word_q;
      ram_be   = 4'b0000;
      case (state_q)
         IDLE: begin
            if (i_req_valid) begin
               state_d = req_err ? RESP : BEAT0;
            end
         end
         BEAT0: begin
            ram_en  = 1'b1;
            ram_be  = wren_q ? mask0_q : 4'b0000;
            state_d = split_q ? BEAT1 : RESP;
         end
         BEAT1: begin
            ram_en   = 1'b1;
            ram_addr = word_q + AW'(1);
            ram_be   = wren_q ? mask1_q : 4'b0000;
            state_d  = RESP;
         end
         RESP: begin
            if (i_rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   sp_bram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .i_clk   (i_clk),
      .i_en    (ram_en),
      .i_be    (ram_be),
      .i_addr  (ram_addr),
      .i_wdata (wdata_q),
      .o_rdata (ram_rdata)
   );

   // Inputs are the RAM read register (idle in RESP) and hold_q, so the result is stable under backpressure.
   always_comb begin
      if (split_q) begin
         case (off_q)
            2'd1:    aligned = {ram_rdata[7:0],  hold_q};
            2'd2:    aligned = {ram_rdata[15:0], hold_q[23:8]};
            2'd3:    aligned = {ram_rdata[23:0], hold_q[23:16]};
            default: aligned = ram_rdata;
         endcase
      end else begin
         aligned = ram_rdata >> {off_q, 3'b000};
      end
      case (size_q)
         LSU_BYTE: load_val = signed_q ? {{24{aligned[7]}}, aligned[7:0]}
                                       : {24'd0, aligned[7:0]};
         LSU_HALF: load_val = signed_q ? {{16{aligned[15]}}, aligned[15:0]}
                                       : {16'd0, aligned[15:0]};
         default:  load_val = aligned;
      endcase
   end

   assign o_req_ready = (state_q == IDLE);
   assign o_rsp_valid = (state_q == RESP);
   assign o_rsp_err   = o_rsp_valid && err_q;
   assign o_rsp_rdata = (o_rsp_valid && !wren_q && !err_q) ? load_val : 32'd0;
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed and randomized checks of lsu_mem_responder against a byte-addressed memory model.
module tb_lsu_mem_responder;
   import lsu_pkg::*;

   logic           clk = 1'b0;
   logic           rst;
   logic           req_valid;
   logic           req_ready;
   logic [31:0]    req_addr;
   logic           req_wren;
   logic [1:0]     req_size;
   logic           req_signed;
   logic [31:0]    req_wdata;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [31:0]    rsp_rdata;
   logic           rsp_err;
   lsu_rsp_state_e dbg_state;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] mdl_mem [2048];
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   lsu_mem_responder dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_addr   (req_addr),
      .i_req_wren   (req_wren),
      .i_req_size   (req_size),
      .i_req_signed (req_signed),
      .i_req_wdata  (req_wdata),
      .o_rsp_valid  (rsp_valid),
      .i_rsp_ready  (rsp_ready),
      .o_rsp_rdata  (rsp_rdata),
      .o_rsp_err    (rsp_err),
      .o_dbg_state  (dbg_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model: flat little-endian byte array ----------------
   function automatic int nbytes(input logic [1:0] size);
      return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic mdl_err(input logic [31:0] addr, input logic [1:0] size);
      return (longint'(addr) + longint'(nbytes(size)) - 1) > longint'(DMEM_LIMIT);
   endfunction

   function automatic logic [31:0] mdl_load(input logic [31:0] addr, input logic [1:0] size,
                                            input logic sgn);
      logic [31:0] v = 32'd0;
      int n = nbytes(size);
      for (int i = 0; i < n; i++) v = v | (32'(mdl_mem[int'(addr) + i]) << (8 * i));
      if (sgn && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (sgn && n == 2 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   task automatic mdl_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] d);
      for (int i = 0; i < nbytes(size); i++) mdl_mem[int'(addr) + i] = d[8*i +: 8];
   endtask

   function automatic int mdl_lat(input logic [31:0] addr, input logic [1:0] size);
      if (mdl_err(addr, size)) return 1;
      return ((addr >> 2) != ((addr + 32'(nbytes(size) - 1)) >> 2)) ? 3 : 2;
   endfunction

   // ---------------- driver ----------------
   // lat counts the accept cycle as T, so a response visible right after the accept edge is T+1.
   task automatic do_req(input logic [31:0] addr, input logic wren, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wdata, input int bp,
                         output logic [31:0] rd, output logic er, output int lat);
      int guard = 0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_addr   = addr;
      req_wren   = wren;
      req_size   = size;
      req_signed = sgn;
      req_wdata  = wdata;
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) chk("req_ready_timeout", 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_wdata = $urandom();
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rd = rsp_rdata;
      er = rsp_err;
      for (int i = 0; i < bp; i++) begin
         chk("bp_rdata_stable", rsp_rdata, rd);
         chk("bp_err_stable", 32'(rsp_err), 32'(er));
         chk("bp_valid_held", 32'(rsp_valid), 32'd1);
         chk("bp_req_ready_low", 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   task automatic run_model(input string tag, input logic [31:0] addr, input logic wren,
                            input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                            input int bp);
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic        e_err = mdl_err(addr, size);
      int          e_lat = mdl_lat(addr, size);
      exp_q.push_back((wren || e_err) ? 32'd0 : mdl_load(addr, size, sgn));
      do_req(addr, wren, size, sgn, wdata, bp, rd, er, lat);
      chk({tag, "_rdata"}, rd, exp_q.pop_front());
      chk({tag, "_err"}, 32'(er), 32'(e_err));
      chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
      if (wren && !e_err) mdl_store(addr, size, wdata);
   endtask

   task automatic run_const(input string tag, input logic [31:0] addr, input logic wren,
                            input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                            input logic [31:0] e_rd, input logic e_err, input int e_lat);
      logic [31:0] rd;
      logic        er;
      int          lat;
      do_req(addr, wren, size, sgn, wdata, 0, rd, er, lat);
      chk({tag, "_rdata"}, rd, e_rd);
      chk({tag, "_err"}, 32'(er), 32'(e_err));
      chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
      if (wren && !e_err) mdl_store(addr, size, wdata);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] keep;

      // ---------------- reset ----------------
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_addr   = '0;
      req_wren   = 1'b0;
      req_size   = '0;
      req_signed = 1'b0;
      req_wdata  = '0;
      rsp_ready  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      rst = 1'b0;
      #1 chk("rst_req_ready", 32'(req_ready), 32'd1);

      // ---------------- fill memory so the model knows every byte ----------------
      for (int w = 0; w < 512; w++) run_model("init", 32'(w * 4), 1'b1, LSU_WORD, 1'b0, $urandom(), 0);

      // ---------------- directed cases ----------------
      run_const("sw_aligned", 32'h010, 1'b1, LSU_WORD, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b0, 2);
      run_const("lw_aligned", 32'h010, 1'b0, LSU_WORD, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b0, 2);

      run_model("sw_020", 32'h020, 1'b1, LSU_WORD, 1'b0, 32'h80FF_7F01, 0);
      run_const("lb_022",  32'h022, 1'b0, LSU_BYTE, 1'b1, 32'd0, 32'hFFFF_FFFF, 1'b0, 2);
      run_const("lbu_023", 32'h023, 1'b0, LSU_BYTE, 1'b0, 32'd0, 32'h0000_0080, 1'b0, 2);
      run_const("lh_022",  32'h022, 1'b0, LSU_HALF, 1'b1, 32'd0, 32'hFFFF_80FF, 1'b0, 2);
      run_const("lhu_020", 32'h020, 1'b0, LSU_HALF, 1'b0, 32'd0, 32'h0000_7F01, 1'b0, 2);

      run_model("sw_040", 32'h040, 1'b1, LSU_WORD, 1'b0, 32'h3322_1100, 0);
      run_model("sw_044", 32'h044, 1'b1, LSU_WORD, 1'b0, 32'h7766_5544, 0);
      run_const("lw_split_041", 32'h041, 1'b0, LSU_WORD, 1'b0, 32'd0, 32'h4433_2211, 1'b0, 3);
      run_const("sw_split_043", 32'h043, 1'b1, LSU_WORD, 1'b0, 32'hAABB_CCDD, 32'd0, 1'b0, 3);
      run_const("lw_after_040", 32'h040, 1'b0, LSU_WORD, 1'b0, 32'd0, 32'hDD22_1100, 1'b0, 2);
      run_const("lw_after_044", 32'h044, 1'b0, LSU_WORD, 1'b0, 32'd0, 32'h77AA_BBCC, 1'b0, 2);

      run_const("sh_split_047", 32'h047, 1'b1, LSU_HALF, 1'b0, 32'h0000_1234, 32'd0, 1'b0, 3);
      run_const("lhu_split_047", 32'h047, 1'b0, LSU_HALF, 1'b0, 32'd0, 32'h0000_1234, 1'b0, 3);
      run_const("lw_sh_044", 32'h044, 1'b0, LSU_WORD, 1'b0, 32'd0, 32'h34AA_BBCC, 1'b0, 2);
      run_model("lw_sh_048", 32'h048, 1'b0, LSU_WORD, 1'b0, 32'd0, 0);

      run_const("lw_err_7fe", 32'h7FE, 1'b0, LSU_WORD, 1'b0, 32'd0, 32'd0, 1'b1, 1);
      run_const("sw_err_800", 32'h800, 1'b1, LSU_WORD, 1'b0, 32'hCAFE_F00D, 32'd0, 1'b1, 1);
      run_const("sw_err_7fd", 32'h7FD, 1'b1, LSU_WORD, 1'b0, 32'hCAFE_F00D, 32'd0, 1'b1, 1);
      run_model("lw_7fc_kept", 32'h7FC, 1'b0, LSU_WORD, 1'b0, 32'd0, 0);
      run_model("lw_000_kept", 32'h000, 1'b0, LSU_WORD, 1'b0, 32'd0, 0);
      run_model("lb_7ff_ok", 32'h7FF, 1'b0, LSU_BYTE, 1'b1, 32'd0, 0);

      run_model("bp_lw_041", 32'h041, 1'b0, LSU_WORD, 1'b0, 32'd0, 5);
      run_model("bp_lh_022", 32'h022, 1'b0, LSU_HALF, 1'b1, 32'd0, 5);

      // ---------------- reset while in BEAT0 of a store ----------------
      // Store data equals what the model already holds, so the word stays consistent either way.
      keep = mdl_load(32'h100, LSU_WORD, 1'b0);
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = 32'h100;
      req_wren  = 1'b1;
      req_size  = LSU_WORD;
      req_wdata = keep;
      @(posedge clk);
      #1;
      chk("beat0_reached", 32'(dbg_state), 32'(BEAT0));
      rst       = 1'b1;
      req_valid = 1'b0;
      #1;
      chk("rst_b0_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_b0_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_b0_rsp_err", 32'(rsp_err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("rst_b0_req_ready", 32'(req_ready), 32'd1);
      run_model("post_rst_lw_100", 32'h100, 1'b0, LSU_WORD, 1'b0, 32'd0, 0);

      // ---------------- randomized traffic ----------------
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         logic [1:0]  sz;
         if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(32'h7F0, 32'h80F));
         else                           a = 32'($urandom_range(0, 32'h7FF));
         sz = 2'($urandom_range(0, 3));
         run_model("rand", a, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                   $urandom(), ($urandom_range(0, 7) == 0) ? 2 : 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lsu_mem_responder.md
# lsu_mem_responder

Memory-side responder for load/store requests issued by the LSU. It owns a single-port, byte-maskable data RAM and accepts one request at a time over a valid/ready handshake. A word access that crosses a word boundary is split into two sequential RAM beats, and so is a half-word access that crosses one. The merged, sign/zero-extended result is returned over a valid/ready response channel. It replaces the instant dual-port memory model in cycle-accurate builds.

## Interface
- DEPTH_WORDS, 512: RAM depth in 32-bit words (2 KiB, byte addresses 0x000–0x7FF).
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- i_clk  in  1  clock; all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  responder can accept a request.
- i_req_addr  in  32  byte address.
- i_req_wren  in  1  1 = store, 0 = load.
- i_req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- i_req_signed  in  1  sign-extend byte/half loads.
- i_req_wdata  in  32  store data, LSB-aligned.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  consumer accepts the response.
- o_rsp_rdata  out  32  load result. Always 0 for stores and for errors.
- o_rsp_err  out  1  the address range check failed.

## Operation
- Accept: the request is taken when i_req_valid && o_req_ready. At that moment addr, wren, size, signed and wdata are all latched. o_req_ready = (state == IDLE).
- Decode: word index W = (addr − BASE_ADDR) >> 2, byte offset off = addr[1:0].
- Split rule: a word access with off != 0 splits. A half access with off == 3 splits. All other accesses use one beat.
- Lane masks and data alignment follow byte-lane order:
  - Beat 0 covers lanes off.. up to lane 3.
  - Beat 1 covers the remaining low lanes of word W+1.
  - Store data is rotated left by 8·off bits.
- Range check: the error is evaluated at accept.
  - The check fails if any byte of the access lies outside [BASE_ADDR, BASE_ADDR + 4·DEPTH_WORDS − 1]. This includes a split whose W+1 wraps past the last word.
  - On error, no RAM write occurs on either word. The FSM goes straight to RESP with err = 1 and rdata = 0.
- States:
  - IDLE → BEAT0 on accept, or → RESP on accept with a range error.
  - BEAT0: drive W and mask0; write if store. → BEAT1 if split, else → RESP.
  - BEAT1: capture beat-0 read data into a hold register; drive W+1 and mask1; write if store. → RESP.
  - RESP: o_rsp_valid = 1. → IDLE when i_rsp_ready.
- Load assembly in RESP:
  - Merge the hold register (low lanes from W) with the RAM output (high lanes from W+1). An unsplit access uses the RAM output only.
  - Shift right by 8·off.
  - Extend from bit 7 (byte) or bit 15 (half) when signed, otherwise zero-fill.
- Store response: o_rsp_valid with rdata = 0 and err = 0. The write is complete before the response is presented.

## Timing
- RAM is synchronous: the address and write are driven in a beat, and read data is valid the following cycle.
- Latency from the accept edge T:
  - Unsplit access: o_rsp_valid at T+2.
  - Split access: o_rsp_valid at T+3.
  - Range error: o_rsp_valid at T+1.
- Back-to-back requests: the next accept can occur in the cycle after the response handshake, since IDLE is re-entered. Throughput is therefore one request per 3 cycles at best.
- Backpressure: in RESP, o_rsp_rdata and o_rsp_err are held stable until i_rsp_ready. They are registered outputs, with no combinational path from the RAM to the ports after RESP entry.
- The request and response channels never handshake in the same cycle, because ready is only asserted in IDLE.
- Reset:
  - State → IDLE; o_rsp_valid, o_rsp_rdata and o_rsp_err → 0.
  - o_req_ready is 1 in the first cycle after reset release.
  - RAM contents are not cleared.
  - A reset during BEAT1 of a split store leaves beat 0 written and beat 1 unwritten. This is the documented behaviour.

## Structure
- Shared package lsu_pkg holds:
  - Size encodings LSU_BYTE, LSU_HALF, LSU_WORD.
  - The responder state enum IDLE/BEAT0/BEAT1/RESP.
  - The DMEM base and limit constants.
- One sub-module, sp_bram: single-port RAM with DEPTH_WORDS × 32 bits, a 4-bit byte-write mask and synchronous read. It has no reset.

## Test plan
- Aligned word: store 0xDEADBEEF @0x010, then load word @0x010. Required: store response at T+2 with err = 0; load returns 0xDEADBEEF at T+2.
- Signed and unsigned byte/half loads, with word 0x80FF7F01 @0x020:
  - lb @0x022 → 0xFFFFFFFF.
  - lbu @0x023 → 0x00000080.
  - lh @0x022 → 0xFFFF80FF.
  - lhu @0x020 → 0x00007F01.
- Split word, with words 0x33221100 @0x040 and 0x77665544 @0x044:
  - Load word @0x041 → 0x44332211 at T+3.
  - Store 0xAABBCCDD @0x043 → words become 0xDD221100 and 0x77AABBCC.
- Split half: store half 0x1234 @0x047, then load @0x047 → 0x00001234. Only lane 3 of 0x044 and lane 0 of 0x048 change.
- Range error: load word @0x7FE and store @0x800.
  - Both respond at T+1 with err = 1 and rdata = 0.
  - Words 0x7FC and 0x000 are unchanged.
- Backpressure and reset:
  - Hold i_rsp_ready = 0 for 5 cycles. rdata must stay stable and o_req_ready must stay 0.
  - Assert i_reset in BEAT0. All outputs go to 0 and o_req_ready = 1 after release.
